// File: rtl/event_record_src_arbiter.sv
// event_record_src_arbiter
//
// Two-source, burst-aware arbiter in front of the event-record unpacker.
// Source 0 is the UART bridge, source 1 the internal record generator. A grant
// is held from the first beat of a burst through tlast, so bursts never
// interleave. The selected beat is registered in a single output stage that
// also carries the source ID (m_tid).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_enable            0 blocks new grants; a burst in progress completes
//   cfg_fixed_prio        1 = source 0 always wins, 0 = round-robin
//   s0_* / s1_*           AXI-Stream slave inputs (tdata/tvalid/tready/tlast)
//   m_*                   registered AXI-Stream master output plus m_tid
//   busy                  a burst is currently granted
//   cnt_s0_rec/cnt_s1_rec beats forwarded per source
//   cnt_stall             cycles with m_tvalid=1 and m_tready=0
//
// Build option: define ARB_STATS_EN to implement the three statistics
// counters; otherwise the counter ports are tied to zero.

module event_record_src_arbiter #(
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_enable,
  input  logic              cfg_fixed_prio,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic              s0_tlast,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic              s1_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tid,
  output logic              busy,
  output logic [31:0]       cnt_s0_rec,
  output logic [31:0]       cnt_s1_rec,
  output logic [31:0]       cnt_stall
);

  typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] m_tdata_q;
  logic              m_tvalid_q, m_tlast_q, m_tid_q;

  logic              out_rdy;
  logic              any_valid;
  logic              win_now;
  logic              win_next;
  logic              sel;
  logic              sel_en;
  logic              sel_last;
  logic              acc;

  // Winner when both request: fixed priority favours source 0, otherwise the
  // source that did not win last time.
  function automatic logic arb_pick(logic v0, logic v1, logic fixed, logic lg);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    if (fixed)     return 1'b0;
    return ~lg;
  endfunction

  always_comb begin
    out_rdy   = m_tready || !m_tvalid_q;
    any_valid = s0_tvalid || s1_tvalid;
    win_now   = arb_pick(s0_tvalid, s1_tvalid, cfg_fixed_prio, last_grant_q);
    sel       = 1'b0;
    sel_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        sel    = win_now;
        sel_en = cfg_enable && any_valid;
      end
      StG0: begin
        sel    = 1'b0;
        sel_en = 1'b1;
      end
      StG1: begin
        sel    = 1'b1;
        sel_en = 1'b1;
      end
      default: ;
    endcase

    // rst_n gating keeps both readies low for the whole reset pulse.
    s0_tready = rst_n && sel_en && !sel && out_rdy;
    s1_tready = rst_n && sel_en &&  sel && out_rdy;
    acc       = (s0_tvalid && s0_tready) || (s1_tvalid && s1_tready);
    sel_last  = sel ? s1_tlast : s0_tlast;

    // Re-arbitration at end of burst sees the just-finished source as last_grant,
    // which lets the next burst start on the following cycle without a bubble.
    win_next     = arb_pick(s0_tvalid, s1_tvalid, cfg_fixed_prio, sel);
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (acc) begin
      last_grant_d = sel;
      if (!sel_last) begin
        state_d = sel ? StG1 : StG0;
      end else if (cfg_enable && any_valid) begin
        state_d = win_next ? StG1 : StG0;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output stage: a load takes priority over clearing on an output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= 1'b0;
    end else if (acc) begin
      m_tdata_q  <= sel ? s1_tdata : s0_tdata;
      m_tvalid_q <= 1'b1;
      m_tlast_q  <= sel_last;
      m_tid_q    <= sel;
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tid    = m_tid_q;
  assign busy     = (state_q != StIdle);

`ifdef ARB_STATS_EN
  logic [31:0] cnt_s0_q, cnt_s1_q, cnt_stall_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_s0_q    <= '0;
      cnt_s1_q    <= '0;
      cnt_stall_q <= '0;
    end else begin
      if (s0_tvalid && s0_tready) cnt_s0_q <= cnt_s0_q + 32'd1;
      if (s1_tvalid && s1_tready) cnt_s1_q <= cnt_s1_q + 32'd1;
      if (m_tvalid_q && !m_tready) cnt_stall_q <= cnt_stall_q + 32'd1;
    end
  end

  assign cnt_s0_rec = cnt_s0_q;
  assign cnt_s1_rec = cnt_s1_q;
  assign cnt_stall  = cnt_stall_q;
`else
  assign cnt_s0_rec = '0;
  assign cnt_s1_rec = '0;
  assign cnt_stall  = '0;
`endif

endmodule

// File: tb/tb_event_record_src_arbiter.sv
// Self-checking bench for event_record_src_arbiter: directed scenarios followed
// by randomized traffic, all compared against a behavioural model that tracks
// grant owner, output beat and per-source counts.
module tb_event_record_src_arbiter;

  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_enable = 1'b0;
  logic          cfg_fixed_prio = 1'b0;
  logic [DW-1:0] s0_tdata = '0;
  logic          s0_tvalid = 1'b0;
  logic          s0_tready;
  logic          s0_tlast = 1'b0;
  logic [DW-1:0] s1_tdata = '0;
  logic          s1_tvalid = 1'b0;
  logic          s1_tready;
  logic          s1_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          m_tid;
  logic          busy;
  logic [31:0]   cnt_s0_rec, cnt_s1_rec, cnt_stall;

  always #5 clk = ~clk;

  event_record_src_arbiter #(.DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_enable    (cfg_enable),
    .cfg_fixed_prio(cfg_fixed_prio),
    .s0_tdata      (s0_tdata),
    .s0_tvalid     (s0_tvalid),
    .s0_tready     (s0_tready),
    .s0_tlast      (s0_tlast),
    .s1_tdata      (s1_tdata),
    .s1_tvalid     (s1_tvalid),
    .s1_tready     (s1_tready),
    .s1_tlast      (s1_tlast),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .m_tid         (m_tid),
    .busy          (busy),
    .cnt_s0_rec    (cnt_s0_rec),
    .cnt_s1_rec    (cnt_s1_rec),
    .cnt_stall     (cnt_stall)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    pct0 = 100;
  int    pct1 = 100;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner -1 = nobody holds a grant.
  int            e_owner;
  logic          e_lg;
  logic          e_valid, e_last, e_tid;
  logic [DW-1:0] e_data;
  logic [31:0]   e_c0, e_c1, e_st;

  // Observations of the DUT, used by directed scenarios.
  int obs_tid[$];
  int obs_cyc[$];
  int obs_last[$];
  int obs_acc0, obs_acc1;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic pick(logic v0, logic v1, logic fx, logic lg);
    if (v0 && !v1) return 1'b0;
    if (!v0 && v1) return 1'b1;
    return fx ? 1'b0 : !lg;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_burst(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = rand_data();
      b.last = (k == len - 1);
      if (src == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic raise_valids();
    if (!s0_tvalid && q0.size() > 0 && int'($urandom_range(99)) < pct0) begin
      s0_tvalid = 1'b1;
      s0_tdata  = q0[0].data;
      s0_tlast  = q0[0].last;
    end
    if (!s1_tvalid && q1.size() > 0 && int'($urandom_range(99)) < pct1) begin
      s1_tvalid = 1'b1;
      s1_tdata  = q1[0].data;
      s1_tlast  = q1[0].last;
    end
  endtask

  task automatic model_reset();
    e_owner = -1;
    e_lg    = 1'b1;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_tid   = 1'b0;
    e_data  = '0;
    e_c0    = '0;
    e_c1    = '0;
    e_st    = '0;
  endtask

  task automatic clear_obs();
    obs_tid.delete();
    obs_cyc.delete();
    obs_last.delete();
    obs_acc0 = 0;
    obs_acc1 = 0;
  endtask

  // One clock cycle: starts and ends just after a falling edge.
  task automatic step();
    logic          v0, v1, orr, r0, r1, acc, blast, h0, h1;
    int            sel, n_owner;
    logic          n_lg, n_valid, n_last, n_tid;
    logic [DW-1:0] n_data;
    logic [31:0]   n_c0, n_c1, n_st;
    raise_valids();
    #1;
    v0  = s0_tvalid;
    v1  = s1_tvalid;
    orr = m_tready || !e_valid;
    sel = -1;
    if (e_owner < 0) begin
      if (cfg_enable && (v0 || v1)) sel = pick(v0, v1, cfg_fixed_prio, e_lg) ? 1 : 0;
    end else begin
      sel = e_owner;
    end
    r0 = (sel == 0) && orr;
    r1 = (sel == 1) && orr;

    check_eq("s0_tready", DW'(s0_tready), DW'(r0));
    check_eq("s1_tready", DW'(s1_tready), DW'(r1));
    check_eq("m_tvalid", DW'(m_tvalid), DW'(e_valid));
    check_eq("m_tdata", m_tdata, e_data);
    check_eq("m_tlast", DW'(m_tlast), DW'(e_last));
    check_eq("m_tid", DW'(m_tid), DW'(e_tid));
    check_eq("busy", DW'(busy), DW'(e_owner >= 0));
    check_eq("cnt_s0_rec", DW'(cnt_s0_rec), DW'(e_c0));
    check_eq("cnt_s1_rec", DW'(cnt_s1_rec), DW'(e_c1));
    check_eq("cnt_stall", DW'(cnt_stall), DW'(e_st));

    h0 = s0_tvalid && s0_tready;
    h1 = s1_tvalid && s1_tready;
    if (h0) obs_acc0++;
    if (h1) obs_acc1++;
    if (m_tvalid && m_tready) begin
      obs_tid.push_back(int'(m_tid));
      obs_cyc.push_back(cyc);
      obs_last.push_back(int'(m_tlast));
    end

    n_owner = e_owner;
    n_lg    = e_lg;
    n_valid = e_valid;
    n_last  = e_last;
    n_tid   = e_tid;
    n_data  = e_data;
    n_c0    = e_c0;
    n_c1    = e_c1;
    n_st    = e_st;
`ifdef ARB_STATS_EN
    if (e_valid && !m_tready) n_st = e_st + 32'd1;
`endif
    acc = (r0 && v0) || (r1 && v1);
    if (acc) begin
      blast   = (sel == 1) ? s1_tlast : s0_tlast;
      n_valid = 1'b1;
      n_data  = (sel == 1) ? s1_tdata : s0_tdata;
      n_last  = blast;
      n_tid   = (sel == 1);
      n_lg    = (sel == 1);
`ifdef ARB_STATS_EN
      if (sel == 1) n_c1 = e_c1 + 32'd1;
      else n_c0 = e_c0 + 32'd1;
`endif
      if (!blast) n_owner = sel;
      else if (cfg_enable && (v0 || v1)) n_owner = pick(v0, v1, cfg_fixed_prio, n_lg) ? 1 : 0;
      else n_owner = -1;
    end else if (e_valid && m_tready) begin
      n_valid = 1'b0;
      n_last  = 1'b0;
    end

    @(posedge clk);
    e_owner = n_owner;
    e_lg    = n_lg;
    e_valid = n_valid;
    e_last  = n_last;
    e_tid   = n_tid;
    e_data  = n_data;
    e_c0    = n_c0;
    e_c1    = n_c1;
    e_st    = n_st;
    cyc++;
    @(negedge clk);
    if (h0 && q0.size() > 0) begin
      void'(q0.pop_front());
      s0_tvalid = 1'b0;
    end
    if (h1 && q1.size() > 0) begin
      void'(q1.pop_front());
      s1_tvalid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_m_tvalid", DW'(m_tvalid), '0);
    check_eq("rst_m_tdata", m_tdata, '0);
    check_eq("rst_m_tid", DW'(m_tid), '0);
    check_eq("rst_m_tlast", DW'(m_tlast), '0);
    check_eq("rst_busy", DW'(busy), '0);
    check_eq("rst_s0_tready", DW'(s0_tready), '0);
    check_eq("rst_s1_tready", DW'(s1_tready), '0);
    check_eq("rst_cnt_s0", DW'(cnt_s0_rec), '0);
    check_eq("rst_cnt_s1", DW'(cnt_s1_rec), '0);
    check_eq("rst_cnt_stall", DW'(cnt_stall), '0);
    model_reset();
    q0.delete();
    q1.delete();
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    model_reset();
    clear_obs();
    @(negedge clk);

    // Alternating 3-beat bursts under round-robin, no bubbles.
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    m_tready  = 1'b1;
    apply_reset();
    cfg_enable     = 1'b1;
    cfg_fixed_prio = 1'b0;
    push_burst(0, 3);
    push_burst(1, 3);
    run(9);
    check_eq("rr_count", DW'(obs_tid.size()), DW'(6));
    for (int i = 0; i < 6; i++) begin
      check_eq("rr_tid", DW'((i < obs_tid.size()) ? obs_tid[i] : 9), DW'((i < 3) ? 0 : 1));
      check_eq("rr_last", DW'((i < obs_last.size()) ? obs_last[i] : 9),
               DW'((i == 2 || i == 5) ? 1 : 0));
    end
    check_eq("rr_nobubble", DW'((obs_cyc.size() == 6) ? obs_cyc[5] - obs_cyc[0] : 99), DW'(5));

    // Fixed priority: continuous single-beat records on source 0 starve source 1.
    apply_reset();
    cfg_fixed_prio = 1'b1;
    for (int i = 0; i < 20; i++) push_burst(0, 1);
    push_burst(1, 2);
    run(20);
    check_eq("fp_s0_acc", DW'(obs_acc0), DW'(20));
    check_eq("fp_s1_acc", DW'(obs_acc1), DW'(0));

    // Source 0 arrives mid-burst of source 1 and waits for tlast.
    apply_reset();
    cfg_fixed_prio = 1'b0;
    push_burst(1, 4);
    run(1);
    push_burst(0, 2);
    run(6);
    check_eq("hold_count", DW'(obs_tid.size()), DW'(6));
    for (int i = 0; i < 6; i++)
      check_eq("hold_tid", DW'((i < obs_tid.size()) ? obs_tid[i] : 9), DW'((i < 4) ? 1 : 0));
    check_eq("hold_nobubble", DW'((obs_cyc.size() == 6) ? obs_cyc[5] - obs_cyc[0] : 99), DW'(5));

    // Output stall for 5 cycles.
    apply_reset();
    push_burst(0, 3);
    held = q0[0].data;
    run(1);
    m_tready = 1'b0;
    run(5);
    check_eq("stall_data", m_tdata, held);
    check_eq("stall_tid", DW'(m_tid), '0);
`ifdef ARB_STATS_EN
    check_eq("stall_cnt", DW'(cnt_stall), DW'(5));
`else
    check_eq("stall_cnt", DW'(cnt_stall), DW'(0));
`endif
    m_tready = 1'b1;
    run(4);

    // Enable drops at beat 2 of a 4-beat burst.
    apply_reset();
    cfg_enable = 1'b1;
    push_burst(0, 4);
    run(2);
    cfg_enable = 1'b0;
    push_burst(1, 2);
    run(5);
    check_eq("dis_busy", DW'(busy), '0);
    check_eq("dis_s0_acc", DW'(obs_acc0), DW'(4));
    check_eq("dis_s1_acc", DW'(obs_acc1), DW'(0));
    cfg_enable = 1'b1;
    clear_obs();
    step();
    check_eq("reen_grant", DW'(obs_acc1), DW'(1));
    run(3);

    // Reset mid-burst, then source 0 wins first contention.
    apply_reset();
    push_burst(0, 4);
    run(1);
    raise_valids();
    apply_reset();
    push_burst(0, 1);
    push_burst(1, 1);
    run(4);
    check_eq("post_rst_first", DW'((obs_tid.size() > 0) ? obs_tid[0] : 9), DW'(0));
    check_eq("post_rst_count", DW'(obs_tid.size()), DW'(2));

    // Randomized traffic.
    apply_reset();
    cfg_enable     = 1'b1;
    cfg_fixed_prio = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      m_tready = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 4) cfg_enable = ~cfg_enable;
      if ($urandom_range(99) < 2) cfg_fixed_prio = ~cfg_fixed_prio;
      pct0 = int'($urandom_range(100, 40));
      pct1 = int'($urandom_range(100, 40));
      if (q0.size() < 6 && $urandom_range(99) < 30) push_burst(0, int'($urandom_range(4, 1)));
      if (q1.size() < 6 && $urandom_range(99) < 30) push_burst(1, int'($urandom_range(4, 1)));
      if ($urandom_range(999) == 0) apply_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
